// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// MEM_ARB_RR_EN (see mem_arb_pick) selects round-robin instead of fixed load priority.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        LD_ACC = 2'd2
    } state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LD = 1'b1;

    // Wide enough for STARVE_MAX up to 15.
    localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for mem_arbiter.
// Default: fixed load priority with fetch starvation limit; MEM_ARB_RR_EN: round-robin.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                rst_i,
    input  logic                if_req_i,
    input  logic                ld_req_i,
    input  logic [STARVE_W-1:0] starve_cnt_i,
    input  logic                last_i,
    output logic                if_gnt_o,
    output logic                ld_gnt_o,
    output logic [STARVE_W-1:0] starve_cnt_o,
    output logic                last_o
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    always_comb begin
        if_gnt_o = 1'b0;
        ld_gnt_o = 1'b0;
        if (!rst_i) begin
            if (if_req_i && ld_req_i) begin
`ifdef MEM_ARB_RR_EN
                if (last_i == REQ_LD) begin
                    if_gnt_o = 1'b1;
                end else begin
                    ld_gnt_o = 1'b1;
                end
`else
                if (starve_cnt_i == STARVE_LIM) begin
                    if_gnt_o = 1'b1;
                end else begin
                    ld_gnt_o = 1'b1;
                end
`endif
            end else begin
                if_gnt_o = if_req_i;
                ld_gnt_o = ld_req_i;
            end
        end
    end

    always_comb begin
        starve_cnt_o = '0;
`ifndef MEM_ARB_RR_EN
        // Count only cycles where fetch is waiting; a grant or a dropped request restarts it.
        if (if_req_i && !if_gnt_o) begin
            if (starve_cnt_i == STARVE_LIM) begin
                starve_cnt_o = starve_cnt_i;
            end else begin
                starve_cnt_o = starve_cnt_i + 1'b1;
            end
        end
`endif
    end

    always_comb begin
        last_o = last_i;
        if (if_gnt_o) begin
            last_o = REQ_IF;
        end else if (ld_gnt_o) begin
            last_o = REQ_LD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/load) arbiter for a single combinational-read memory port.
// Arbitration policy is chosen in mem_arb_pick via MEM_ARB_RR_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    output logic              ld_gnt_o,
    output logic              ld_rvalid_o,
    output logic [DATA_W-1:0] ld_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                last_q, last_d;

    mem_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .rst_i       (rst),
        .if_req_i    (if_req_i),
        .ld_req_i    (ld_req_i),
        .starve_cnt_i(starve_q),
        .last_i      (last_q),
        .if_gnt_o    (if_gnt_o),
        .ld_gnt_o    (ld_gnt_o),
        .starve_cnt_o(starve_d),
        .last_o      (last_d)
    );

    always_comb begin
        state_d = IDLE;
        addr_d  = addr_q;
        if (if_gnt_o) begin
            state_d = IF_ACC;
            addr_d  = if_addr_i;
        end else if (ld_gnt_o) begin
            state_d = LD_ACC;
            addr_d  = ld_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            starve_q <= '0;
            last_q   <= REQ_IF;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            starve_q <= starve_d;
            last_q   <= last_d;
        end
    end

    // Gating with rst drops a response whose accept preceded the reset cycle.
    assign if_rvalid_o = (state_q == IF_ACC) && !rst;
    assign ld_rvalid_o = (state_q == LD_ACC) && !rst;
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign ld_rdata_o  = ld_rvalid_o ? mem_rdata_i : '0;
    assign mem_addr_o  = rst ? '0 : addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter; memory model returns address + 3.
// Honours MEM_ARB_RR_EN for the contention grant patterns.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req, ld_req;
    logic [31:0] if_addr, ld_addr;
    logic        if_gnt, ld_gnt, if_rvalid, ld_rvalid;
    logic [31:0] if_rdata, ld_rdata, mem_addr, mem_rdata;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_gnt_o   (if_gnt),
        .if_rvalid_o(if_rvalid),
        .if_rdata_o (if_rdata),
        .ld_req_i   (ld_req),
        .ld_addr_i  (ld_addr),
        .ld_gnt_o   (ld_gnt),
        .ld_rvalid_o(ld_rvalid),
        .ld_rdata_o (ld_rdata),
        .mem_addr_o (mem_addr),
        .mem_rdata_i(mem_rdata)
    );

    assign mem_rdata = mem_addr + 32'h3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: every rvalid pops one expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_rvalid && ld_rvalid) begin
                chk("dual_rvalid", 32'(if_rvalid & ld_rvalid), 32'd0);
            end else if (if_rvalid || ld_rvalid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rvalid", {30'd0, ld_rvalid, if_rvalid}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_id", {31'd0, ld_rvalid}, {31'd0, e.id});
                    chk("rsp_data", ld_rvalid ? ld_rdata : if_rdata, e.data);
                    chk("loser_rdata", ld_rvalid ? if_rdata : ld_rdata, 32'd0);
                end
            end
        end
    end

    task automatic drive(input logic ir, input logic [31:0] ia, input logic lr,
                         input logic [31:0] la, input logic eig, input logic elg,
                         input logic [31:0] edata, input logic push);
        exp_t e;
        if_req  = ir;
        if_addr = ia;
        ld_req  = lr;
        ld_addr = la;
        @(negedge clk);
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, eig});
        chk("ld_gnt", {31'd0, ld_gnt}, {31'd0, elg});
        if (push && (eig || elg)) begin
            e.id   = elg;
            e.data = edata;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int unsigned n);
        rst     = 1'b1;
        if_req  = 1'b1;
        ld_req  = 1'b1;
        if_addr = 32'h55;
        ld_addr = 32'h66;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
            chk("rst_ld_gnt", {31'd0, ld_gnt}, 32'd0);
            chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
            chk("rst_ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
            chk("rst_if_rdata", if_rdata, 32'd0);
            chk("rst_ld_rdata", ld_rdata, 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            @(posedge clk);
            #1;
        end
        rst    = 1'b0;
        if_req = 1'b0;
        ld_req = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        end
    endtask

    initial begin
        logic [9:0] pat_a;
        logic [1:0] pat_b;
        logic [4:0] pat_c;
`ifdef MEM_ARB_RR_EN
        pat_a = 10'b1010101010;
        pat_b = 2'b10;
        pat_c = 5'b10101;
`else
        pat_a = 10'b1000010000;
        pat_b = 2'b00;
        pat_c = 5'b10000;
`endif
        rst     = 1'b1;
        if_req  = 1'b0;
        ld_req  = 1'b0;
        if_addr = '0;
        ld_addr = '0;
        @(posedge clk);
        #1;
        do_reset(2);

        // Fetch-only, then mem_addr must hold through idle cycles
        drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h13, 1'b1);
        idle(2);
        chk("mem_addr_hold", mem_addr, 32'h10);

        // Back-to-back fetches
        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3, 1'b1);
        drive(1'b1, 32'h4, 1'b0, 32'h0, 1'b1, 1'b0, 32'h7, 1'b1);
        drive(1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 1'b0, 32'hB, 1'b1);
        idle(1);

        // Load-only
        drive(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h43, 1'b1);
        idle(1);

        // Continuous contention from reset
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h100, 1'b1, 32'h200, pat_a[i], !pat_a[i],
                  pat_a[i] ? 32'h103 : 32'h203, 1'b1);
        end
        idle(1);

        // Fetch withdrawn while load holds memory; starvation must restart
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h100, 1'b1, 32'h200, pat_b[i], !pat_b[i],
                  pat_b[i] ? 32'h103 : 32'h203, 1'b1);
        end
        drive(1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 32'h203, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h100, 1'b1, 32'h200, pat_c[i], !pat_c[i],
                  pat_c[i] ? 32'h103 : 32'h203, 1'b1);
        end
        idle(1);

        // Reset right after a load accept discards its response
        drive(1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 1'b1, 32'h23, 1'b0);
        do_reset(1);
        drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h13, 1'b1);
        idle(1);

        for (int i = 0; i < 4 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, max consecutive fetch-losing cycles before forced fetch grant (range 1..15).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-006 SHALL have ports if_req_i input 1, if_addr_i input ADDR_W, if_gnt_o output 1, if_rvalid_o output 1, if_rdata_o output DATA_W: instruction-fetch requester.
REQ-007 SHALL have ports ld_req_i input 1, ld_addr_i input ADDR_W, ld_gnt_o output 1, ld_rvalid_o output 1, ld_rdata_o output DATA_W: data-load requester.
REQ-008 SHALL have ports mem_addr_o output ADDR_W (to single-read-port memory) and mem_rdata_i input DATA_W (combinational read data for mem_addr_o).

Function
REQ-009 SHALL share one combinational-read memory between the fetch and load requesters; at most one grant per cycle.
REQ-010 Handshake: request accepted in cycle N iff req_i and gnt_o both high in N; gnt_o is combinational from req_i and arbiter state.
REQ-011 Requester SHALL hold addr_i stable while req_i high and gnt_o low; dropping req_i before grant is legal and cancels the request.
REQ-012 On accept in cycle N, addr_i SHALL register into mem_addr_o at end of N; winner's rvalid_o high in N+1 with rdata_o = mem_rdata_i; loser's rvalid_o low, rdata_o = 0.
REQ-013 Back-to-back accepts SHALL sustain one response per cycle, no bubble.
REQ-014 FSM states IDLE, IF_ACC, LD_ACC record the previous cycle's accept; next state = IF_ACC/LD_ACC per that cycle's winner, else IDLE; rvalid outputs decode from state.
REQ-015 Single requester active SHALL be granted same cycle.
REQ-016 Both active: load wins, unless starvation count equals STARVE_MAX, then fetch wins.
REQ-017 Starvation count SHALL increment when if_req_i high and not granted, clear on fetch accept or if_req_i low, and saturate at STARVE_MAX.
REQ-018 mem_addr_o SHALL hold its last value while IDLE.

Reset
REQ-019 In a rst cycle: gnt_o outputs low, state IDLE, both rvalid_o low, rdata_o 0, mem_addr_o 0, starvation count 0.
REQ-020 Reset asserted mid-transfer SHALL discard the in-flight response; no rvalid_o in the cycle after reset deasserts.

Configuration
REQ-021 Macro MEM_ARB_RR_EN defined: on simultaneous requests, grant goes to the requester not granted most recently (load first after reset); starvation counter and STARVE_MAX unused.
REQ-022 Macro MEM_ARB_RR_EN undefined: fixed load priority with starvation counter per REQ-016/017.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the FSM state enum (IDLE, IF_ACC, LD_ACC) and requester ID constants (REQ_IF=0, REQ_LD=1).
REQ-024 Winner selection (priority, starvation or round-robin) SHALL live in sub-module mem_arb_pick; mem_arbiter holds registers and FSM.

Verification
REQ-025 Fetch-only: if_req_i=1, if_addr_i=0x0000_0010, memory returns 0x0000_0013 -> if_gnt_o=1 same cycle, if_rvalid_o=1 next cycle with if_rdata_o=0x0000_0013.
REQ-026 Contention, fixed priority: both requesting continuously, STARVE_MAX=4 -> ld granted 4 cycles, if granted 5th, pattern repeats; no cycle with two grants.
REQ-027 Round-robin build (MEM_ARB_RR_EN): both requesting continuously -> grants alternate LD, IF, LD, IF from reset.
REQ-028 Back-to-back fetch at 0x0,0x4,0x8 -> rvalid high three consecutive cycles, rdata matches each address in order.
REQ-029 rst asserted in the cycle after a load accept -> ld_rvalid_o stays 0; all outputs at reset values; first post-reset fetch behaves per REQ-025.
REQ-030 Fetch request withdrawn before grant while load holds memory -> no if_rvalid_o pulse, starvation count returns to 0.
